config_chain_master: RTL and testbench

CONFIG_CHAIN_MASTER -- requirements
Module: config_chain_master

---
 rtl/config_chain_master_pkg.sv | 18 +
 rtl/fp_pkg.sv | 6 +
 rtl/config_if.sv | 10 +
 rtl/config_chain_master_timer.sv | 39 +++
 rtl/config_chain_master.sv | 148 ++++++++++++++
 tb/tb_config_chain_master.sv | 265 ++++++++++++++++++++++++++
 6 files changed

// File: rtl/config_chain_master_pkg.sv
// config_chain_master_pkg: state encoding and parameter defaults for the
// configuration chain master.
package config_chain_master_pkg;

  localparam int unsigned CCM_CHAIN_LEN_DEF = 24;
  localparam int unsigned CCM_CLK_DIV_DEF   = 2;
  localparam int unsigned CCM_CNT_W         = 16;
  localparam int unsigned CCM_TMR_W         = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_LOW  = 3'd2,
    ST_HIGH = 3'd3,
    ST_FIN  = 3'd4
  } ccm_state_e;

endpackage

// File: rtl/fp_pkg.sv
// fp: shared numeric word type for configuration chains.
package fp;

  typedef logic [15:0] fpType;

endpackage

// File: rtl/config_if.sv
// config_if: serial configuration link (data_clk + parallel data word).
interface config_if;

  logic      data_clk;
  fp::fpType data_in;

  modport master (output data_clk, output data_in);
  modport slave  (input  data_clk, input  data_in);

endinterface

// File: rtl/config_chain_master_timer.sv
// clk_phase_timer: counts DIV clk cycles after a load and flags the last one.
// o_expire is high during the DIV-th cycle after i_load; a load in the same
// cycle as expiry restarts the count seamlessly.
module clk_phase_timer
  import config_chain_master_pkg::*;
#(
  parameter int unsigned DIV = CCM_CLK_DIV_DEF
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  output logic o_expire
);

  localparam logic [CCM_TMR_W-1:0] LP_RELOAD = 8'(DIV - 1);

  logic [CCM_TMR_W-1:0] r_count;
  logic                 r_run;

  // down-counter, reload has priority over counting
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
      r_run   <= 1'b0;
    end else if (i_load) begin
      r_count <= LP_RELOAD;
      r_run   <= 1'b1;
    end else if (r_run) begin
      if (r_count == '0) begin
        r_run <= 1'b0;
      end else begin
        r_count <= r_count - 8'd1;
      end
    end
  end

  assign o_expire = r_run && (r_count == '0);

endmodule

// File: rtl/config_chain_master.sv
// config_chain_master: shifts CHAIN_LEN host words into a serial config chain
// using a divided data_clk (CLK_DIV clk cycles per phase).
// Optional feature macro: CFG_READBACK_EN -- captures the chain tail on each
// shift so the previous chain contents stream out on rd_valid/rd_data.
module config_chain_master
  import config_chain_master_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = CCM_CHAIN_LEN_DEF,
  parameter int unsigned CLK_DIV   = CCM_CLK_DIV_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            wr_valid,
  input  fp::fpType       wr_data,
  output logic            wr_ready,
  output logic            busy,
  output logic            done,
  config_if.master        cfg_out,
  config_if.slave         cfg_ret,
  output logic            rd_valid,
  output fp::fpType       rd_data
);

  localparam logic [CCM_CNT_W-1:0] LP_CHAIN_LEN = 16'(CHAIN_LEN);

  ccm_state_e           r_state;
  logic                 r_wr_ready;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_data_clk;
  fp::fpType            r_data_in;
  logic [CCM_CNT_W-1:0] r_word_cnt;

  logic w_wr_fire;
  logic w_tmr_load;
  logic w_tmr_expire;
  logic w_shift;
  logic w_unused_ret;

  assign w_wr_fire  = wr_valid && r_wr_ready;
  assign w_shift    = (r_state == ST_LOW) && w_tmr_expire;
  assign w_tmr_load = w_wr_fire || w_shift;

  clk_phase_timer #(
    .DIV (CLK_DIV)
  ) u_timer (
    .i_clk    (clk),
    .i_rst    (reset),
    .i_load   (w_tmr_load),
    .o_expire (w_tmr_expire)
  );

  // pass sequencer with all host/chain outputs registered alongside the state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_wr_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_data_clk <= 1'b0;
      r_data_in  <= '0;
      r_word_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state    <= ST_LOAD;
            r_wr_ready <= 1'b1;
            r_busy     <= 1'b1;
            r_word_cnt <= '0;
          end
        end
        ST_LOAD: begin
          if (w_wr_fire) begin
            r_state    <= ST_LOW;
            r_wr_ready <= 1'b0;
            r_data_in  <= wr_data;
          end
        end
        ST_LOW: begin
          if (w_tmr_expire) begin
            r_state    <= ST_HIGH;
            r_data_clk <= 1'b1;
            r_word_cnt <= r_word_cnt + 16'd1;
          end
        end
        ST_HIGH: begin
          if (w_tmr_expire) begin
            r_data_clk <= 1'b0;
            if (r_word_cnt < LP_CHAIN_LEN) begin
              r_state    <= ST_LOAD;
              r_wr_ready <= 1'b1;
            end else begin
              r_state <= ST_FIN;
              r_done  <= 1'b1;
            end
          end
        end
        ST_FIN: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state    <= ST_IDLE;
          r_wr_ready <= 1'b0;
          r_busy     <= 1'b0;
          r_done     <= 1'b0;
          r_data_clk <= 1'b0;
        end
      endcase
    end
  end

  assign wr_ready         = r_wr_ready;
  assign busy             = r_busy;
  assign done             = r_done;
  assign cfg_out.data_clk = r_data_clk;
  assign cfg_out.data_in  = r_data_in;

`ifdef CFG_READBACK_EN
  logic      r_rd_valid;
  fp::fpType r_rd_data;

  // sample the chain tail in the cycle before data_clk rises, i.e. pre-shift
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= w_shift;
      if (w_shift) begin
        r_rd_data <= cfg_ret.data_in;
      end
    end
  end

  assign rd_valid     = r_rd_valid;
  assign rd_data      = r_rd_data;
  assign w_unused_ret = cfg_ret.data_clk;
`else
  assign rd_valid     = 1'b0;
  assign rd_data      = '0;
  assign w_unused_ret = cfg_ret.data_clk ^ (^cfg_ret.data_in);
`endif

endmodule

// File: tb/tb_config_chain_master.sv
// tb_config_chain_master: drives two master instances (6-deep/div-2 and
// 1-deep/div-1) against behavioural slave chains and checks the results
// against the sequence of words the host pushed.
module tb_config_chain_master;

  localparam int unsigned CL6 = 6;
  localparam int unsigned CD6 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT 6 ----------------
  logic      rst6 = 1'b1;
  logic      start6 = 1'b0;
  logic      wr_valid6 = 1'b0;
  fp::fpType wr_data6 = '0;
  logic      wr_ready6, busy6, done6, rd_valid6;
  fp::fpType rd_data6;
  config_if  cfg6_out ();
  config_if  cfg6_ret ();

  config_chain_master #(.CHAIN_LEN(CL6), .CLK_DIV(CD6)) u_dut6 (
    .clk(clk), .reset(rst6), .start(start6), .wr_valid(wr_valid6),
    .wr_data(wr_data6), .wr_ready(wr_ready6), .busy(busy6), .done(done6),
    .cfg_out(cfg6_out), .cfg_ret(cfg6_ret), .rd_valid(rd_valid6), .rd_data(rd_data6)
  );

  // ---------------- DUT 1 ----------------
  logic      rst1 = 1'b1;
  logic      start1 = 1'b0;
  logic      wr_valid1 = 1'b0;
  fp::fpType wr_data1 = '0;
  logic      wr_ready1, busy1, done1, rd_valid1;
  fp::fpType rd_data1;
  config_if  cfg1_out ();
  config_if  cfg1_ret ();

  config_chain_master #(.CHAIN_LEN(1), .CLK_DIV(1)) u_dut1 (
    .clk(clk), .reset(rst1), .start(start1), .wr_valid(wr_valid1),
    .wr_data(wr_data1), .wr_ready(wr_ready1), .busy(busy1), .done(done1),
    .cfg_out(cfg1_out), .cfg_ret(cfg1_ret), .rd_valid(rd_valid1), .rd_data(rd_data1)
  );

  // ---------------- slave chain models ----------------
  fp::fpType chain6 [CL6];
  int        edges6 = 0;
  logic      pre_stb = 1'b0;
  fp::fpType chain1 = '0;
  int        edges1 = 0;

  always @(posedge cfg6_out.data_clk or posedge pre_stb) begin
    if (pre_stb) begin
      for (int k = 0; k < CL6; k++) chain6[k] = 16'hA0 + 16'(k);
    end else begin
      for (int k = CL6 - 1; k > 0; k--) chain6[k] = chain6[k-1];
      chain6[0] = cfg6_out.data_in;
      edges6++;
    end
  end

  always @(posedge cfg1_out.data_clk) begin
    chain1 = cfg1_out.data_in;
    edges1++;
  end

  assign cfg6_ret.data_in  = chain6[CL6-1];
  assign cfg6_ret.data_clk = 1'b0;
  assign cfg1_ret.data_in  = chain1;
  assign cfg1_ret.data_clk = 1'b0;

  // ---------------- scoreboard ----------------
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // ---------------- waveform monitor for DUT 6 ----------------
  int        done_cnt6 = 0;
  int        hi_run6 = 0, hi_bad6 = 0, setup_bad6 = 0, since6 = 0, rd_nz6 = 0;
  logic      prev_clk6 = 1'b0;
  fp::fpType last_din6 = '0;
  fp::fpType rd_q [$];

  always @(negedge clk) begin
    if (rst6) begin
      hi_run6   = 0;
      since6    = 0;
      prev_clk6 = 1'b0;
      last_din6 = cfg6_out.data_in;
    end else begin
      if (cfg6_out.data_in !== last_din6) since6 = 0;
      else since6++;
      last_din6 = cfg6_out.data_in;
      if (cfg6_out.data_clk && !prev_clk6 && since6 != int'(CD6)) setup_bad6++;
      if (cfg6_out.data_clk) hi_run6++;
      else if (prev_clk6) begin
        if (hi_run6 != int'(CD6)) hi_bad6++;
        hi_run6 = 0;
      end
      prev_clk6 = cfg6_out.data_clk;
      if (done6) done_cnt6++;
      if (rd_valid6) rd_q.push_back(rd_data6);
      if (rd_valid6 || rd_data6 != '0) rd_nz6++;
    end
  end

  // ---------------- host driver for DUT 6 ----------------
  fp::fpType   pass_w     [CL6];
  int unsigned pass_stall [CL6];

  task automatic run_pass6(input int abort_idx);
    int        cyc, bad, done0, edges0;
    fp::fpType snap [CL6];
    for (int k = 0; k < CL6; k++) snap[k] = chain6[k];
    rd_q.delete();
    done0  = done_cnt6;
    edges0 = edges6;
    @(negedge clk); start6 = 1'b1;
    @(negedge clk); start6 = 1'b0;
    check_val("busy_after_start", busy6, 1);
    for (int i = 0; i < CL6; i++) begin
      cyc = 0;
      while (!wr_ready6 && cyc < 200) begin @(negedge clk); cyc++; end
      check_val("wr_ready_wait", wr_ready6, 1);
      bad = 0;
      for (int s = 0; s < int'(pass_stall[i]); s++) begin
        @(negedge clk);
        if (cfg6_out.data_clk !== 1'b0 || wr_ready6 !== 1'b1) bad++;
        if (i > 0 && cfg6_out.data_in !== pass_w[i-1]) bad++;
      end
      if (pass_stall[i] > 0) check_val("stall_hold", bad, 0);
      wr_valid6 = 1'b1;
      wr_data6  = pass_w[i];
      @(negedge clk);
      wr_valid6 = 1'b0;
      wr_data6  = 16'($urandom);
      check_val("data_in_reg", cfg6_out.data_in, pass_w[i]);
      check_val("wr_ready_drop", wr_ready6, 0);
      if (i == abort_idx) begin
        cyc = 0;
        while (!cfg6_out.data_clk && cyc < 50) begin @(negedge clk); cyc++; end
        check_val("abort_in_high", cfg6_out.data_clk, 1);
        #2 rst6 = 1'b1;
        @(negedge clk);
        check_val("abort_data_clk", cfg6_out.data_clk, 0);
        check_val("abort_busy", busy6, 0);
        check_val("abort_done", done6, 0);
        check_val("abort_data_in", cfg6_out.data_in, 0);
        #2 rst6 = 1'b0;
        repeat (4) @(negedge clk);
        check_val("abort_no_done", done_cnt6 - done0, 0);
        return;
      end
    end
    cyc = 0;
    while (!done6 && cyc < 200) begin @(negedge clk); cyc++; end
    check_val("done_seen", done6, 1);
    check_val("done_busy", busy6, 1);
    @(negedge clk);
    check_val("busy_fall", busy6, 0);
    check_val("done_once_wide", done6, 0);
    repeat (3) @(negedge clk);
    check_val("done_count", done_cnt6 - done0, 1);
    check_val("edge_count", edges6 - edges0, CL6);
    for (int k = 0; k < CL6; k++) check_val("chain_word", chain6[CL6-1-k], pass_w[k]);
    check_val("last_on_data_in", cfg6_out.data_in, pass_w[CL6-1]);
    check_val("high_width", hi_bad6, 0);
    check_val("setup_width", setup_bad6, 0);
`ifdef CFG_READBACK_EN
    check_val("rd_count", rd_q.size(), CL6);
    for (int k = 0; k < CL6 && k < rd_q.size(); k++)
      check_val("rd_word", rd_q[k], snap[CL6-1-k]);
`else
    check_val("rd_tied_zero", rd_nz6, 0);
    check_val("rd_snapshot_unused", snap[0], snap[0] & 16'hFFFF);
`endif
  endtask

  // ---------------- main sequence ----------------
  fp::fpType prevw;
  fp::fpType w1;

  initial begin
    rst6 = 1'b1;
    rst1 = 1'b1;
    repeat (2) @(negedge clk);
    check_val("rst_wr_ready", wr_ready6, 0);
    check_val("rst_busy", busy6, 0);
    check_val("rst_done", done6, 0);
    check_val("rst_data_clk", cfg6_out.data_clk, 0);
    check_val("rst_data_in", cfg6_out.data_in, 0);
    check_val("rst_rd_valid", rd_valid6, 0);
    check_val("rst_rd_data", rd_data6, 0);
    check_val("rst1_busy", busy1, 0);
    check_val("rst1_rd", {rd_valid1, rd_data1}, 0);
    #2;
    rst6 = 1'b0;
    rst1 = 1'b0;
    pre_stb = 1'b1;
    #1 pre_stb = 1'b0;

    // words 1..6, no stall, chain preloaded 0xA0..0xA5
    for (int i = 0; i < CL6; i++) begin pass_w[i] = 16'(i + 1); pass_stall[i] = 0; end
    run_pass6(CL6);

    // host withholds the 3rd word for 10 cycles
    pass_stall[2] = 10;
    run_pass6(CL6);

    // reset during HIGH of the 4th word, then a clean full pass
    pass_stall[2] = 0;
    run_pass6(3);
    run_pass6(CL6);

    // random words with random host stalls
    prevw = pass_w[CL6-1];
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < CL6; i++) begin
        pass_w[i] = 16'($urandom);
        if (pass_w[i] == prevw) pass_w[i] = prevw ^ 16'h0001;
        prevw = pass_w[i];
        pass_stall[i] = $urandom_range(0, 3);
      end
      run_pass6(CL6);
    end

    // single-word chain, CLK_DIV=1, start re-pulsed while busy
    w1 = 16'($urandom);
    @(negedge clk); start1 = 1'b1; wr_valid1 = 1'b1; wr_data1 = w1;
    @(negedge clk); start1 = 1'b0;
    check_val("c1_busy", busy1, 1);
    check_val("c1_wr_ready", wr_ready1, 1);
    @(negedge clk); wr_valid1 = 1'b0; start1 = 1'b1;
    check_val("c1_low_clk", cfg1_out.data_clk, 0);
    check_val("c1_data_in", cfg1_out.data_in, w1);
    @(negedge clk); start1 = 1'b0;
    check_val("c1_high_clk", cfg1_out.data_clk, 1);
    check_val("c1_high_done", done1, 0);
    @(negedge clk);
    check_val("c1_fin_clk", cfg1_out.data_clk, 0);
    check_val("c1_fin_done", done1, 1);
    @(negedge clk);
    check_val("c1_idle_busy", busy1, 0);
    check_val("c1_idle_done", done1, 0);
    repeat (6) @(negedge clk);
    check_val("c1_start_ignored", busy1, 0);
    check_val("c1_no_ready", wr_ready1, 0);
    check_val("c1_edges", edges1, 1);
    check_val("c1_chain", chain1, w1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_checks);
    $fatal(1, "time limit");
  end

endmodule
